// File: rtl/instr_fetch_latch_if.sv
// Handshake and bus bundle between the control unit, instruction memory and the fetch stage.
interface instr_fetch_latch_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;

  logic            fetch_req;
  logic [XLEN-1:0] pc_in;
  logic            ir_clear;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rd;
  logic [XLEN-1:0] ir_out;
  logic [OP_W-1:0] opcode;
  logic [XLEN-1:0] imm_raw;
  logic            ext_op;
  logic            busy;
  logic            fetch_done;
  logic            fetch_err;

  // Environment side: control unit plus memory model.
  modport master (
    output fetch_req, pc_in, ir_clear, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, ir_out, opcode, imm_raw, ext_op, busy, fetch_done, fetch_err
  );

  // Fetch stage side.
  modport slave (
    input  fetch_req, pc_in, ir_clear, mem_rdata, mem_ready,
    output mem_addr, mem_rd, ir_out, opcode, imm_raw, ext_op, busy, fetch_done, fetch_err
  );
endinterface

// File: rtl/instr_fetch_latch.sv
// Fetch-and-hold stage: reads one instruction word through a ready handshake with a
// bounded wait, holds it in IR, and decodes the raw immediate for the extender.
module instr_fetch_latch #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_latch_if.slave bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0]  ir;
  logic [XLEN-1:0]  addr_q;
  logic             rd_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [5:0]       op;
  logic [XLEN-1:0]  imm;
  logic             ext;

  // Fetch FSM with registered strobes; ready beats timeout on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ir       <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fetch_req) begin
            addr_q   <= bus.pc_in;
            rd_q     <= 1'b1;
            busy_q   <= 1'b1;
            wait_cnt <= '0;
            state    <= REQ;
          end else if (bus.ir_clear) begin
            ir <= '0;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            ir     <= bus.mem_rdata;
            rd_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (wait_cnt >= MAX_CNT - CNT_W'(1)) begin
            wait_cnt <= MAX_CNT;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Immediate field select; always zero-padded, sign handling is downstream.
  always_comb begin
    op  = ir[31:26];
    imm = {16'b0, ir[15:0]};
    ext = 1'b1;
    if (op[5:4] == 2'b11) begin
      imm = {6'b0, ir[25:0]};
    end else if (op == 6'h0C || op == 6'h0D) begin
      ext = 1'b0;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd     = rd_q;
  assign bus.ir_out     = ir;
  assign bus.opcode     = op;
  assign bus.imm_raw    = imm;
  assign bus.ext_op     = ext;
  assign bus.busy       = busy_q;
  assign bus.fetch_done = done_q;
  assign bus.fetch_err  = err_q;
endmodule

// File: tb/tb_instr_fetch_latch.sv
// Self-checking bench for instr_fetch_latch: directed steps plus randomized fetches
// checked against a transaction-level reference model.
module tb_instr_fetch_latch;
  localparam int unsigned MAX_WAIT = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [31:0] m_ir;
  logic [31:0] m_addr;

  instr_fetch_latch_if bus ();

  instr_fetch_latch #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the immediate rules.
  task automatic chk_decode(input string tag);
    logic [5:0]  op;
    logic [31:0] imm;
    logic        ext;
    op  = m_ir[31:26];
    imm = (op >= 6'd48) ? (m_ir & 32'h03FF_FFFF) : (m_ir & 32'h0000_FFFF);
    ext = !(op == 6'd12 || op == 6'd13);
    chk({tag, "_ir"},     bus.ir_out,            m_ir);
    chk({tag, "_opcode"}, 32'(bus.opcode),       32'(op));
    chk({tag, "_imm"},    bus.imm_raw,           imm);
    chk({tag, "_ext"},    32'(bus.ext_op),       32'(ext));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_rd"}, 32'(bus.mem_rd),     32'd0);
    chk({tag, "_busy"},   32'(bus.busy),       32'd0);
    chk({tag, "_done"},   32'(bus.fetch_done), 32'd0);
    chk({tag, "_err"},    32'(bus.fetch_err),  32'd0);
    chk({tag, "_addr"},   bus.mem_addr,        32'd0);
    chk({tag, "_ir"},     bus.ir_out,          32'd0);
    chk({tag, "_opcode"}, 32'(bus.opcode),     32'd0);
    chk({tag, "_imm"},    bus.imm_raw,         32'd0);
    chk({tag, "_ext"},    32'(bus.ext_op),     32'd1);
  endtask

  // Idle cycles: no pulses, IR and address held; optional clear in IDLE.
  task automatic idle(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      bus.fetch_req = 1'b0;
      bus.ir_clear  = clr;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      bus.ir_clear = 1'b0;
      if (clr) m_ir = '0;
      chk("idle_done", 32'(bus.fetch_done), 32'd0);
      chk("idle_err",  32'(bus.fetch_err),  32'd0);
      chk("idle_busy", 32'(bus.busy),       32'd0);
      chk("idle_addr", bus.mem_addr,        m_addr);
      chk_decode("idle");
    end
  endtask

  // One fetch; starts and ends on a falling edge. rdy_at = REQ edge with ready (0 = never).
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int rdy_at, input bit noisy, input bit clear_too);
    int outcome;
    bus.fetch_req = 1'b1;
    bus.pc_in     = addr;
    bus.ir_clear  = clear_too;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.ir_clear  = 1'b0;
    bus.pc_in     = $urandom;
    m_addr        = addr;
    chk("req_busy",   32'(bus.busy),   32'd1);
    chk("req_mem_rd", 32'(bus.mem_rd), 32'd1);
    chk("req_addr",   bus.mem_addr,    m_addr);
    chk("req_ir",     bus.ir_out,      m_ir);
    outcome = 0;
    for (int k = 1; k <= int'(MAX_WAIT) + 1 && outcome == 0; k++) begin
      bus.mem_ready = (k == rdy_at);
      bus.mem_rdata = (k == rdy_at) ? data : $urandom;
      if (noisy) begin
        bus.fetch_req = 1'($urandom);
        bus.ir_clear  = 1'($urandom);
        bus.pc_in     = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.fetch_req = 1'b0;
      bus.ir_clear  = 1'b0;
      if (k == rdy_at) begin
        outcome = 1;
        m_ir    = data;
      end else if (k == int'(MAX_WAIT)) begin
        outcome = 2;
      end
      chk("cyc_done",   32'(bus.fetch_done), 32'(outcome == 1));
      chk("cyc_err",    32'(bus.fetch_err),  32'(outcome == 2));
      chk("cyc_busy",   32'(bus.busy),       32'(outcome == 0));
      chk("cyc_mem_rd", 32'(bus.mem_rd),     32'(outcome == 0));
      chk("cyc_addr",   bus.mem_addr,        m_addr);
      chk_decode("cyc");
    end
    if (outcome == 0) chk("fetch_terminated", 32'd0, 32'd1);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    m_ir          = '0;
    m_addr        = '0;
    rst_n         = 1'b0;
    bus.fetch_req = 1'b0;
    bus.pc_in     = '0;
    bus.ir_clear  = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset values before any clock edge.
    #1;
    chk_reset_vals("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b0);

    // Basic fetch: ready on 3rd REQ edge, logical-immediate decode.
    do_fetch(32'h0000_0040, 32'h3000_BEEF, 3, 1'b0, 1'b0);
    chk("basic_imm", bus.imm_raw, 32'h0000_BEEF);
    idle(1, 1'b0);

    // J-type then back-to-back fetch accepted while fetch_done is high.
    do_fetch(32'h0000_0100, 32'hFEAD_BEEF, 1, 1'b0, 1'b0);
    chk("jtype_imm", bus.imm_raw, 32'h02AD_BEEF);
    do_fetch(32'h0000_0104, 32'h0800_8001, 2, 1'b0, 1'b0);
    chk("b2b_imm", bus.imm_raw, 32'h0000_8001);
    idle(1, 1'b0);

    // Timeout, then ready exactly on the timeout edge.
    do_fetch(32'h0000_0200, 32'hDEAD_0000, 0, 1'b0, 1'b0);
    idle(1, 1'b0);
    do_fetch(32'h0000_0204, 32'h2400_7FFF, int'(MAX_WAIT), 1'b0, 1'b0);
    idle(1, 1'b0);

    // Inputs toggled during REQ ignored; request beats a simultaneous clear.
    do_fetch(32'h0000_0300, 32'h3400_1234, 3, 1'b1, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Reset pulse between edges.
    do_fetch(32'h0000_0400, 32'h8C00_ABCD, 2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_ir   = '0;
    m_addr = '0;
    chk_reset_vals("rst_pulse");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b0);

    // Reset two cycles into REQ: abort with no pulse afterwards.
    bus.fetch_req = 1'b1;
    bus.pc_in     = 32'h0000_0500;
    @(posedge clk);
    @(negedge clk);
    bus.fetch_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(MAX_WAIT + 2, 1'b0);

    // Randomized fetches with random latency, noise and idle clears.
    for (int n = 0; n < 30; n++) begin
      do_fetch($urandom, $urandom, int'($urandom_range(0, MAX_WAIT + 2)),
               1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_fetch_latch.md
# instr_fetch_latch

Fetch-and-hold stage of the multi-cycle RISC datapath. On a fetch request from the control unit it reads one 32-bit instruction word from instruction memory through a ready-based handshake. It latches the word into the instruction register (IR) and holds it for the rest of the multi-cycle execution. It drives the raw immediate field and the extension-mode select that feed the immediate extender directly downstream, and bounds every memory wait with a timeout.

## Interface
- `MAX_WAIT`, default 15: consecutive not-ready cycles in the request state before a fetch aborts. Legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `fetch_req` input 1: start a fetch. Sampled only in IDLE.
- `pc_in` input 32: fetch address. Captured when `fetch_req` is accepted.
- `ir_clear` input 1: synchronous clear of IR to 0 (NOP). Honoured only in IDLE.
- `mem_rdata` input 32: instruction word from memory. Valid when `mem_ready`=1.
- `mem_ready` input 1: memory completes the read this cycle.
- `mem_addr` output 32: registered fetch address.
- `mem_rd` output 1: read strobe, high throughout the request state.
- `ir_out` output 32: current instruction register contents.
- `opcode` output 6: `ir_out[31:26]`.
- `imm_raw` output 32: unextended immediate for the extender.
- `ext_op` output 1: extender mode, 1 = sign-extend, 0 = zero-extend.
- `busy` output 1: high while in the request state.
- `fetch_done` output 1: one-cycle pulse, IR updated with a new word.
- `fetch_err` output 1: one-cycle pulse, fetch aborted by timeout.

## Operation
- States:
  - IDLE: default.
  - REQ: memory read outstanding.
- IDLE, `fetch_req`=1:
  - `mem_addr`<=`pc_in`, `mem_rd`<=1, wait counter<=0, go to REQ.
  - If `ir_clear` is also 1, the request wins and the clear is dropped.
- IDLE, `fetch_req`=0, `ir_clear`=1: IR<=0. No other state change.
- REQ, `mem_ready`=1:
  - IR<=`mem_rdata`, `mem_rd`<=0, `fetch_done`<=1, go to IDLE.
- REQ, `mem_ready`=0:
  - Wait counter increments.
  - When the counter reaches `MAX_WAIT`: `mem_rd`<=0, `fetch_err`<=1, go to IDLE. IR keeps its previous value.
  - If `mem_ready`=1 on the edge where the timeout would fire, the ready path wins: the fetch completes and no error is raised.
- `fetch_req` and `ir_clear` are ignored in REQ. There is no queuing.
- `fetch_done` and `fetch_err` are never high together. Each stays high for exactly one cycle.
- Wait counter is 8 bits and saturates at `MAX_WAIT`. It never wraps.
- `mem_addr` holds its last value after the fetch completes or aborts.
- Immediate decode, combinational from IR:
  - J-type (`opcode[5:4]`=2'b11): `imm_raw`={6'b0, IR[25:0]}, `ext_op`=1.
  - Logical immediates (`opcode`=6'h0C ANDI, 6'h0D ORI): `imm_raw`={16'b0, IR[15:0]}, `ext_op`=0.
  - All other opcodes: `imm_raw`={16'b0, IR[15:0]}, `ext_op`=1.
  - `imm_raw` is always zero-padded above its field. Sign handling belongs solely to the downstream extender.

## Timing
- Reset (`rst_n`=0, immediate, no clock needed):
  - State IDLE, wait counter 0.
  - IR 0, `mem_addr` 0.
  - `mem_rd`, `busy`, `fetch_done`, `fetch_err` all 0.
  - Consequently `opcode`=0, `imm_raw`=0, `ext_op`=1.
- Reset asserted mid-fetch aborts immediately to the reset values. No `fetch_err` pulse.
- Request accepted on edge E0: `mem_rd`=`busy`=1 from just after E0.
- `mem_ready` sampled high on edge Ek (k≥1):
  - `ir_out` carries the new word and `fetch_done`=1 in the cycle after Ek. `busy`=0 in that cycle.
  - Minimum latency: request edge to `fetch_done` high = 1 cycle (ready on the first REQ edge).
- `imm_raw`/`ext_op` track `ir_out` in the same cycle. Zero added latency.
- A new `fetch_req` may be accepted on the edge where `fetch_done` is high. Back-to-back fetches cost 2 edges minimum per instruction.
- Timeout: with `mem_ready` held 0, `fetch_err` is high in the cycle after the `MAX_WAIT`-th REQ edge.

## Test plan
- Reset check: pulse `rst_n` low between edges → all outputs at their reset values immediately, before any clock edge; `ext_op`=1.
- Basic fetch: `pc_in`=32'h0000_0040, `fetch_req` 1 cycle; `mem_ready`=1 on the 3rd REQ edge with `mem_rdata`=32'h3000_BEEF.
  - `mem_addr`=32'h40 and `mem_rd` high for 3 cycles.
  - Then `fetch_done` pulses once, `ir_out`=32'h3000_BEEF, `opcode`=6'h0C, `imm_raw`=32'h0000_BEEF, `ext_op`=0.
- J-type decode and back-to-back fetch:
  - First fetch returns 32'hFEAD_BEEF: `imm_raw`=32'h02AD_BEEF, `ext_op`=1.
  - `fetch_req` asserted while `fetch_done` is high starts the second fetch at once.
  - Second fetch returns 32'h0800_8001: `imm_raw`=32'h0000_8001, `ext_op`=1.
- Timeout with `MAX_WAIT`=4 and `mem_ready`=0:
  - `fetch_err` pulses on the cycle after the 4th REQ edge; IR unchanged; state returns to IDLE.
  - Repeat with `mem_ready`=1 exactly on the 4th edge → `fetch_done`=1 and `fetch_err`=0.
- Ignored inputs in REQ: toggle `fetch_req` and `ir_clear` during REQ → no effect on `mem_addr` or IR. `ir_clear` in IDLE → `ir_out`=0 on the next cycle.
- Reset mid-fetch: assert `rst_n`=0 two cycles into REQ → `mem_rd` drops immediately; no `fetch_done` or `fetch_err` pulse after release.
